// File: rtl/garbled_pkg.sv
// Shared constants, state encoding and helpers for the garbled-gate evaluator.
// SHA-1 IV, round constants, FSM states and the padding length field.
package garbled_pkg;

  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hefcdab89;
  localparam logic [31:0] H2 = 32'h98badcfe;
  localparam logic [31:0] H3 = 32'h10325476;
  localparam logic [31:0] H4 = 32'hc3d2e1f0;

  localparam logic [31:0] K0 = 32'h5a827999;
  localparam logic [31:0] K1 = 32'h6ed9eba1;
  localparam logic [31:0] K2 = 32'h8f1bbcdc;
  localparam logic [31:0] K3 = 32'hca62c1d6;

  localparam int ROUND_LAST = 79;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUNDS = 2'd1,
    DONE   = 2'd2,
    OUT    = 2'd3
  } state_e;

  // Message bit count placed in the last 64 bits of the padded block.
  function automatic logic [63:0] len_field(input int kw, input int gw);
    return 64'(2 * kw + gw);
  endfunction

endpackage

// File: rtl/garbled_eval_core_w_mem.sv
// SHA-1 message schedule as a 16-word sliding window; w_o is W[t] for the
// current round, and each next_i shifts in W[t+16].
module sha1_w_mem (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [511:0] block_i,
  input  logic         init_i,
  input  logic         next_i,
  output logic [31:0]  w_o
);

  // w_q[15] is the oldest word (W[t]); w_q[15-j] holds W[t+j].
  logic [15:0][31:0] w_q, w_d;
  logic [31:0]       w_new;

  assign w_o = w_q[15];

  always_comb begin
    w_new = w_q[2] ^ w_q[7] ^ w_q[13] ^ w_q[15];
    w_new = {w_new[30:0], w_new[31]};
    w_d   = w_q;
    if (init_i)
      w_d = block_i;
    else if (next_i)
      w_d = {w_q[14:0], w_new};
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      w_q <= '0;
    else
      w_q <= w_d;
  end

endmodule

// File: rtl/garbled_eval_core.sv
// Garbled-gate evaluator: SHA-1 of {kp,kq,gid} XOR a point-and-permute row.
// Optional token compare on the output label: GARBLED_TOKEN_MATCH_EN.
module garbled_eval_core
  import garbled_pkg::*;
#(
  parameter int KW    = 80,
  parameter int GID_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KW-1:0]    kp,
  input  logic [KW-1:0]    kq,
  input  logic [GID_W-1:0] gid,
  input  logic             row_we,
  input  logic [1:0]       row_idx,
  input  logic [KW-1:0]    row_data,
`ifdef GARBLED_TOKEN_MATCH_EN
  input  logic             tok_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KW-1:0]    out_label,
  output logic [1:0]       out_row,
  output logic             out_match,
  output logic             out_bit
);

  localparam int MSG_W = 2 * KW + GID_W;

  generate
    if (KW < 1 || KW > 160 || MSG_W > 447) begin : g_param_chk
      $error("garbled_eval_core: KW must be 1..160 and 2*KW+GID_W <= 447");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [31:0]        a_q, b_q, c_q, d_q, e_q;
  logic [6:0]         ctr_q;
  logic [KW-1:0]      sel_row_q;
  logic [1:0]         idx_q;
  logic [3:0][KW-1:0] rows_q;
  logic [KW-1:0]      out_label_q;
  logic [1:0]         out_row_q;

  logic               accept;
  logic [1:0]         idx_in;
  logic [511:0]       blk;
  logic [31:0]        w;
  logic [31:0]        f, k, temp;
  logic [159:0]       dig;
  logic [KW-1:0]      lbl_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_label = out_label_q;
  assign out_row   = out_row_q;
  assign accept    = in_ready && in_valid;
  assign idx_in    = {kp[0], kq[0]};

  // Single padded block: message, 1-bit marker, zeros, 64-bit length.
  always_comb begin
    blk                = '0;
    blk[511 -: MSG_W]  = {kp, kq, gid};
    blk[511 - MSG_W]   = 1'b1;
    blk[63:0]          = len_field(KW, GID_W);
  end

  sha1_w_mem u_w_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .block_i (blk),
    .init_i  (accept),
    .next_i  (state_q == ROUNDS),
    .w_o     (w)
  );

  always_comb begin
    f = b_q ^ c_q ^ d_q;
    k = K3;
    if (ctr_q < 7'd20) begin
      f = (b_q & c_q) | (~b_q & d_q);
      k = K0;
    end else if (ctr_q < 7'd40) begin
      f = b_q ^ c_q ^ d_q;
      k = K1;
    end else if (ctr_q < 7'd60) begin
      f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k = K2;
    end
    temp = {a_q[26:0], a_q[31:27]} + f + e_q + k + w;
  end

  assign dig   = {H0 + a_q, H1 + b_q, H2 + c_q, H3 + d_q, H4 + e_q};
  assign lbl_d = KW'(dig >> (160 - KW)) ^ sel_row_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ROUNDS;
      ROUNDS:  if (ctr_q == 7'(ROUND_LAST)) state_d = DONE;
      DONE:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      e_q         <= '0;
      ctr_q       <= '0;
      sel_row_q   <= '0;
      idx_q       <= '0;
      out_label_q <= '0;
      out_row_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          a_q       <= H0;
          b_q       <= H1;
          c_q       <= H2;
          d_q       <= H3;
          e_q       <= H4;
          ctr_q     <= '0;
          sel_row_q <= rows_q[idx_in];
          idx_q     <= idx_in;
        end
        ROUNDS: begin
          e_q   <= d_q;
          d_q   <= c_q;
          c_q   <= {b_q[1:0], b_q[31:2]};
          b_q   <= a_q;
          a_q   <= temp;
          ctr_q <= ctr_q + 7'd1;
        end
        DONE: begin
          out_label_q <= lbl_d;
          out_row_q   <= idx_q;
        end
        default: ;
      endcase
    end
  end

`ifdef GARBLED_TOKEN_MATCH_EN
  logic [KW-1:0] tok0_q, tok1_q;
  logic          match_q, bit_q;

  // tok_sel steers the shared write port from the row table to the tokens.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rows_q <= '0;
      tok0_q <= '0;
      tok1_q <= '0;
    end else if (row_we) begin
      if (tok_sel) begin
        if (row_idx[0]) tok1_q <= row_data;
        else            tok0_q <= row_data;
      end else begin
        rows_q[row_idx] <= row_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_q <= 1'b0;
      bit_q   <= 1'b0;
    end else if (state_q == DONE) begin
      match_q <= (lbl_d == tok1_q) || (lbl_d == tok0_q);
      bit_q   <= (lbl_d == tok1_q);
    end
  end

  assign out_match = match_q;
  assign out_bit   = bit_q;
`else
  always_ff @(posedge clk) begin
    if (!reset_n)
      rows_q <= '0;
    else if (row_we)
      rows_q[row_idx] <= row_data;
  end

  assign out_match = 1'b0;
  assign out_bit   = 1'b0;
`endif

endmodule

// File: tb/tb_garbled_eval_core.sv
// Directed bench for garbled_eval_core at KW=8, GID_W=8 using SHA-1("abc").
module tb_garbled_eval_core;

  localparam int KW    = 8;
  localparam int GID_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [KW-1:0]    kp, kq;
  logic [GID_W-1:0] gid;
  logic             row_we;
  logic [1:0]       row_idx;
  logic [KW-1:0]    row_data;
  logic             tok_sel;
  logic             out_valid;
  logic             out_ready;
  logic [KW-1:0]    out_label;
  logic [1:0]       out_row;
  logic             out_match;
  logic             out_bit;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  garbled_eval_core #(.KW(KW), .GID_W(GID_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .kp        (kp),
    .kq        (kq),
    .gid       (gid),
    .row_we    (row_we),
    .row_idx   (row_idx),
    .row_data  (row_data),
`ifdef GARBLED_TOKEN_MATCH_EN
    .tok_sel   (tok_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_label (out_label),
    .out_row   (out_row),
    .out_match (out_match),
    .out_bit   (out_bit)
  );

  typedef struct {
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic write_row(input logic [1:0] idx, input logic [7:0] data, input logic tsel);
    row_we   = 1'b1;
    row_idx  = idx;
    row_data = data;
    tok_sel  = tsel;
    tick();
    row_we  = 1'b0;
    tok_sel = 1'b0;
  endtask

  // Presents "abc" and returns the cycle count at the accept cycle.
  task automatic start_gate(output int t0);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    kp  = 8'h61;
    kq  = 8'h62;
    gid = 8'h63;
    t0  = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int t0, output int lat);
    int n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    lat = cyc - t0;
  endtask

  task automatic gate_check(input string nm, input logic [7:0] exp);
    int t0, lat;
    start_gate(t0);
    wait_out(t0, lat);
    chk({nm, "_latency"}, 32'(lat), 32'd82);
    chk({nm, "_label"}, 32'(out_label), 32'(exp));
    chk({nm, "_row"}, 32'(out_row), 32'd2);
    tick();
  endtask

  initial begin
    int t0, lat;
    logic [7:0] lbl_hold;

    reset_n = 1'b0; in_valid = 1'b0; kp = '0; kq = '0; gid = '0;
    row_we = 1'b0; row_idx = '0; row_data = '0; tok_sel = 1'b0; out_ready = 1'b1;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA9};
    vecs[1] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h56};
    vecs[2] = '{8'h00, 8'h00, 8'hA9, 8'h00, 8'h00};
    vecs[3] = '{8'h33, 8'hC4, 8'h0F, 8'h7E, 8'hA6};
    vecs[4] = '{8'hFF, 8'hFF, 8'h5A, 8'hFF, 8'hF3};

    tick(); tick();
    reset_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_label", 32'(out_label), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    chk("rst_out_match", 32'(out_match), 32'd0);
    chk("rst_out_bit", 32'(out_bit), 32'd0);

    // Table-driven: same gate, varying table contents.
    for (int i = 0; i < 5; i++) begin
      write_row(2'd0, vecs[i].r0, 1'b0);
      write_row(2'd1, vecs[i].r1, 1'b0);
      write_row(2'd2, vecs[i].r2, 1'b0);
      write_row(2'd3, vecs[i].r3, 1'b0);
      gate_check($sformatf("vec%0d", i), vecs[i].exp);
`ifndef GARBLED_TOKEN_MATCH_EN
      chk($sformatf("vec%0d_match", i), 32'(out_match), 32'd0);
`endif
    end

    // Back-pressure: result must hold while the consumer stalls.
    write_row(2'd2, 8'hFF, 1'b0);
    out_ready = 1'b0;
    start_gate(t0);
    wait_out(t0, lat);
    chk("bp_latency", 32'(lat), 32'd82);
    lbl_hold = out_label;
    chk("bp_label", 32'(lbl_hold), 32'h56);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_label_hold", 32'(out_label), 32'(lbl_hold));
      chk("bp_row_hold", 32'(out_row), 32'd2);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Row rewrite at round 40 only affects the following gate.
    start_gate(t0);
    repeat (40) tick();
    write_row(2'd2, 8'h0F, 1'b0);
    wait_out(t0, lat);
    chk("midwr_latency", 32'(lat), 32'd82);
    chk("midwr_label", 32'(out_label), 32'h56);
    tick();
    gate_check("midwr_next", 8'hA6);

    // Write to the selected row in the accept cycle: old value is used.
    write_row(2'd2, 8'h00, 1'b0);
    row_we = 1'b1; row_idx = 2'd2; row_data = 8'hFF;
    start_gate(t0);
    row_we = 1'b0;
    wait_out(t0, lat);
    chk("accwr_label", 32'(out_label), 32'hA9);
    tick();
    gate_check("accwr_next", 8'h56);

    // Reset at round 40 aborts and clears the table.
    write_row(2'd2, 8'h0F, 1'b0);
    gate_check("prerst", 8'hA6);
    start_gate(t0);
    repeat (40) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_label", 32'(out_label), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_row", 32'(out_row), 32'd0);
    gate_check("postrst", 8'hA9);

`ifdef GARBLED_TOKEN_MATCH_EN
    write_row(2'd1, 8'hA9, 1'b1);
    write_row(2'd0, 8'h00, 1'b1);
    gate_check("tok1", 8'hA9);
    chk("tok1_match", 32'(out_match), 32'd1);
    chk("tok1_bit", 32'(out_bit), 32'd1);
    write_row(2'd1, 8'h11, 1'b1);
    gate_check("tok_none", 8'hA9);
    chk("tok_none_match", 32'(out_match), 32'd0);
    chk("tok_none_bit", 32'(out_bit), 32'd0);
    write_row(2'd0, 8'hA9, 1'b1);
    gate_check("tok0", 8'hA9);
    chk("tok0_match", 32'(out_match), 32'd1);
    chk("tok0_bit", 32'(out_bit), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/garbled_eval_core.md
Name: garbled_eval_core

Overview:
- Parametrised garbled-gate evaluator for the garbling fabric.
- Accepts two input wire labels and a gate id, then computes SHA-1 over the padded single block {kp, kq, gid}.
- Selects a garbled-table row by point-and-permute bits and outputs the decrypted output label: truncated digest XOR selected row.
- Successor to the fixed-width, single-token SHA-1 core: label width and gate-id width are parametric, a 4-row garbled table is loadable, and valid/ready handshakes are used on both sides.

Parameters:
- KW, 80: wire-label width in bits. Legal range 1..160.
- GID_W, 64: gate-id width in bits.
- Constraint: 2*KW+GID_W <= 447, so the message plus 1-bit pad plus 64-bit length fits one 512-bit block. An illegal combination is an elaboration error via a generate-time check.

Ports:
- clk in 1: clock.
- reset_n in 1: synchronous, active-low reset.
- in_valid in 1: input labels valid.
- in_ready out 1: core can accept.
- kp in KW: label of wire p.
- kq in KW: label of wire q.
- gid in GID_W: gate id.
- row_we in 1: garbled-table row write strobe.
- row_idx in 2: row address.
- row_data in KW: ciphertext row.
- out_valid out 1: output label valid.
- out_ready in 1: consumer accepts.
- out_label out KW: decrypted output label.
- out_row out 2: row index used.
- out_match out 1: output label equals a stored token (optional feature).
- out_bit out 1: which token matched (optional feature).

Behaviour:
- Reset: out_valid=0, out_label=0, out_row=0, out_match=0, out_bit=0, in_ready=1. All table rows and tokens reset to 0. State=IDLE.
- Block format: {kp, kq, gid, 1'b1, zeros, 64-bit length}, where length = 2*KW+GID_W. This is the standard SHA-1 padding.
- FSM states: IDLE, ROUNDS, DONE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch kp, kq, gid into the block register.
  - Latch row index idx={kp[0],kq[0]} and table row[idx] into sel_row.
  - Init a..e and H to standard IV; round_ctr=0; go to ROUNDS.
- ROUNDS:
  - One SHA-1 round per cycle, rounds 0..79, using standard f/K per 20-round group.
  - After round 79 go to DONE.
- DONE (1 cycle):
  - H = IV + a..e.
  - out_label <= H[159 -: KW] ^ sel_row; out_row <= idx.
  - Go to OUT.
- OUT:
  - out_valid=1; out_label and out_row held stable.
  - On out_ready: out_valid drops next cycle and state returns to IDLE.
  - A new input is accepted no earlier than the cycle after the handshake.
- Latency: handshake at cycle 0 → 80 ROUNDS cycles (1..80) → DONE at 81 → out_valid=1 at cycle 82.
- in_ready=0 in every state except IDLE.
- Table writes:
  - row_we is honoured in every state.
  - The in-flight result uses sel_row latched at accept, so writes during processing affect only later gates.
  - A write in the same cycle as accept, to the selected row: sel_row takes the old value (write is registered).
- Reset mid-operation: abort immediately; all outputs return to reset values next cycle; the table is cleared.
- Arithmetic: all additions are mod 2^32. Truncation takes the most-significant KW digest bits.

Optional Feature:
- Macro: GARBLED_TOKEN_MATCH_EN.
- Defined:
  - Two KW-bit token registers tok0/tok1, written through row_we with row_idx plus an extra port tok_sel (in, 1) qualifying token writes.
  - When tok_sel=1, row_idx[0] selects tok0/tok1.
  - In DONE, the computed label is compared against both tokens.
  - Match on tok1: out_match=1, out_bit=1. Match on tok0 only: out_match=1, out_bit=0. No match: out_match=0, out_bit=0. Both registered alongside out_label.
- Undefined: tok_sel port absent; out_match and out_bit tied 0.

Decomposition:
- Shared package garbled_pkg holds:
  - SHA-1 IV constants H0..H4.
  - Round constants K0..K3.
  - FSM state enum.
  - Round-count constant 79.
  - Helper function for the length field 2*KW+GID_W.
- Sub-module: reuse existing sha1_w_mem for the message schedule (init at accept, next during ROUNDS). No other sub-modules.

Test Plan:
1. SHA-1 "abc", KW=8, GID_W=8:
   - Stimulus: kp=8'h61, kq=8'h62, gid=8'h63, all rows=0.
   - Required: out_row=2, out_label=8'hA9 (digest a9993e36...), out_valid exactly 82 cycles after accept.
2. Same as (1) with row2=8'hFF → out_label=8'h56. Then row2=8'hA9 → out_label=8'h00.
3. Back-pressure:
   - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
   - Required: out_label and out_row stable, in_ready=0 throughout. Raise out_ready → out_valid=0 and in_ready=1 next cycle.
4. Row write during ROUNDS:
   - Stimulus: rewrite row2 to 8'h0F at round 40.
   - Required: current result still 8'h56 (row2=8'hFF at accept). Next identical gate gives 8'hA6.
5. Reset at round 40:
   - Required: out_valid=0, out_label=0, in_ready=1 after reset. A fresh "abc" gate then yields 8'hA9 at the correct latency.
6. With GARBLED_TOKEN_MATCH_EN:
   - Stimulus: tok1=8'hA9, tok0=8'h00, rows=0.
   - Required: out_match=1, out_bit=1. Set tok1=8'h11 → out_match=0, out_bit=0.
